// File: rtl/axi_rd_burst_responder.sv
// AXI4 read subordinate: one AR at a time, walks FIXED/INCR/WRAP bursts into single-beat memory reads.
// AR handshake -> mem_req_o +1 cycle -> r_valid_o +3 cycles; R beat held until r_ready_i, no AR accepted mid-burst.
module axi_rd_burst_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [7:0]            ar_len_i,
  input  logic [2:0]            ar_size_i,
  input  logic [1:0]            ar_burst_i,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i
);

  localparam int unsigned BUS_BYTES = DATA_WIDTH / 8;
  localparam int unsigned BUS_LSB   = $clog2(BUS_BYTES);
  localparam logic [ADDR_WIDTH-1:0] BUS_MASK = ~ADDR_WIDTH'(BUS_BYTES - 1);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, DATA, RESP} state_e;

  state_e                state_q, state_d;
  logic                  armed_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic [7:0]            cnt_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic [1:0]            r_resp_q;

  logic                  ar_hs, r_hs, last_beat, req_err;
  logic [ADDR_WIDTH-1:0] num_bytes, aligned, incr_addr, wrap_len, wrap_lo, wrap_addr, beat_addr;

  assign ar_hs     = ar_valid_i & ar_ready_o;
  assign r_hs      = r_valid_o & r_ready_i;
  assign last_beat = (cnt_q == len_q);

  always_comb begin
    req_err = 1'b0;
    if (ar_burst_i == BURST_RSVD) req_err = 1'b1;
    if (ar_burst_i == BURST_WRAP &&
        !(ar_len_i == 8'd1 || ar_len_i == 8'd3 || ar_len_i == 8'd7 || ar_len_i == 8'd15))
      req_err = 1'b1;
    if (ar_size_i > 3'(BUS_LSB)) req_err = 1'b1;
  end

  // Wrap window is a power of two for every legal WRAP, so masking yields its base.
  always_comb begin
    num_bytes = ADDR_WIDTH'(1) << size_q;
    aligned   = addr_q & ~(num_bytes - ADDR_WIDTH'(1));
    incr_addr = aligned + (ADDR_WIDTH'(cnt_q) << size_q);
    wrap_len  = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
    wrap_lo   = addr_q & ~(wrap_len - ADDR_WIDTH'(1));
    wrap_addr = (incr_addr >= wrap_lo + wrap_len) ? incr_addr - wrap_len : incr_addr;
    beat_addr = addr_q;
    if (cnt_q != 8'd0) begin
      case (burst_q)
        BURST_INCR: beat_addr = incr_addr;
        BURST_WRAP: beat_addr = wrap_addr;
        default:    beat_addr = addr_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ar_hs) state_d = req_err ? RESP : REQ;
      REQ:  state_d = DATA;
      DATA: state_d = RESP;
      RESP: if (r_hs) begin
        if (last_beat)  state_d = IDLE;
        else if (err_q) state_d = RESP;
        else            state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ar_ready_o = (state_q == IDLE) && armed_q;
    mem_req_o  = (state_q == REQ);
    mem_addr_o = (state_q == REQ) ? (beat_addr & BUS_MASK) : '0;
    r_valid_o  = (state_q == RESP);
    r_last_o   = (state_q == RESP) && last_beat;
    r_id_o     = id_q;
    r_data_o   = r_data_q;
    r_resp_o   = r_resp_q;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      armed_q  <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      r_data_q <= '0;
      r_resp_q <= RESP_OKAY;
    end else begin
      armed_q <= 1'b1;
      if (ar_hs) begin
        id_q     <= ar_id_i;
        addr_q   <= ar_addr_i;
        len_q    <= ar_len_i;
        size_q   <= ar_size_i;
        burst_q  <= ar_burst_i;
        err_q    <= req_err;
        cnt_q    <= '0;
        r_data_q <= '0;
        r_resp_q <= req_err ? RESP_SLVERR : RESP_OKAY;
      end
      if (state_q == DATA) begin
        r_data_q <= mem_err_i ? '0 : mem_rdata_i;
        r_resp_q <= mem_err_i ? RESP_SLVERR : RESP_OKAY;
      end
      if (r_hs && !last_beat) cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_responder.sv
// Bench for axi_rd_burst_responder: burst table plus latency, backpressure and reset sequences.
module tb_axi_rd_burst_responder;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic [3:0]  ar_id_i;
  logic [31:0] ar_addr_i;
  logic [7:0]  ar_len_i;
  logic [2:0]  ar_size_i;
  logic [1:0]  ar_burst_i;
  logic        ar_valid_i;
  logic        ar_ready_o;
  logic [3:0]  r_id_o;
  logic [31:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic        r_valid_o;
  logic        r_ready_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  always #5 clk_i = ~clk_i;

  axi_rd_burst_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i),
    .ar_burst_i(ar_burst_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  typedef struct {
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [31:0]      err_addr;
    int               nreq;
    logic [3:0][31:0] ea;
    logic [3:0]       slv;
  } vec_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] exp_maddr[$];
  beat_t       exp_beat[$];
  vec_t        vecs[9];
  logic        hold_v = 1'b0;
  logic [63:0] hold_snap;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic vec_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input logic [31:0] ea_addr,
                              input int nreq, input logic [3:0][31:0] ea, input logic [3:0] slv);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.err_addr = ea_addr; v.nreq = nreq; v.ea = ea; v.slv = slv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous memory: data/err one cycle after the strobe, garbage otherwise.
  always @(posedge clk_i) begin
    mem_rdata_i <= mem_req_o ? mdata(mem_addr_o) : 32'hDEAD_BEEF;
    mem_err_i   <= mem_req_o && (mem_addr_o == err_addr);
  end

  always @(negedge clk_i) begin
    if (!arst_ni) begin
      hold_v = 1'b0;
    end else begin
      if (mem_req_o) begin
        if (exp_maddr.size() == 0) chk("mem_req_unexpected", 64'(mem_req_o), 64'd0);
        else chk("mem_addr", 64'(mem_addr_o), 64'(exp_maddr.pop_front()));
      end
      if (hold_v)
        chk("r_hold", 64'({r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o}), hold_snap);
      if (r_valid_o && r_ready_i) begin
        if (exp_beat.size() == 0) chk("r_beat_unexpected", 64'(r_valid_o), 64'd0);
        else chk("r_beat", 64'({r_id_o, r_data_o, r_resp_o, r_last_o}), 64'(exp_beat.pop_front()));
      end
      hold_v    = r_valid_o && !r_ready_i;
      hold_snap = 64'({r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o});
    end
  end

  task automatic push_vec(input vec_t v);
    beat_t b;
    for (int i = 0; i < v.nreq; i++) exp_maddr.push_back(v.ea[i]);
    for (int i = 0; i <= int'(v.len); i++) begin
      b.id   = v.id;
      b.data = v.slv[i] ? 32'd0 : mdata(v.ea[i]);
      b.resp = v.slv[i] ? 2'b10 : 2'b00;
      b.last = (i == int'(v.len));
      exp_beat.push_back(b);
    end
  endtask

  // Returns one tick after the AR handshake edge.
  task automatic send_ar(input vec_t v);
    int c;
    err_addr   = v.err_addr;
    ar_id_i    = v.id;
    ar_addr_i  = v.addr;
    ar_len_i   = v.len;
    ar_size_i  = v.size;
    ar_burst_i = v.burst;
    ar_valid_i = 1'b1;
    c = 0;
    @(negedge clk_i);
    while (!ar_ready_o && c < 50) begin
      @(negedge clk_i);
      c++;
    end
    if (!ar_ready_o) chk("ar_ready_timeout", 64'(ar_ready_o), 64'd1);
    @(posedge clk_i);
    #1 ar_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_beat.size() != 0 && c < 300) begin
      @(posedge clk_i);
      c++;
    end
    #1;
    if (exp_beat.size() != 0) chk("drain_timeout", 64'(exp_beat.size()), 64'd0);
    chk("mem_req_count", 64'(exp_maddr.size()), 64'd0);
    chk("idle_after_burst", 64'({ar_ready_o, r_valid_o}), 64'b10);
  endtask

  task automatic wait_rvalid();
    int c;
    c = 0;
    while (!r_valid_o && c < 20) begin
      @(posedge clk_i);
      #1;
      c++;
    end
    if (!r_valid_o) chk("r_valid_timeout", 64'(r_valid_o), 64'd1);
  endtask

  initial begin
    vec_t v;
    vecs[0] = mk(4'd5, 32'h1004, 8'd3, 3'd2, 2'b01, 32'hFFFF_FFFF, 4,
                 {32'h1010, 32'h100C, 32'h1008, 32'h1004}, 4'b0000);
    vecs[1] = mk(4'd3, 32'h1008, 8'd3, 3'd2, 2'b10, 32'hFFFF_FFFF, 4,
                 {32'h1004, 32'h1000, 32'h100C, 32'h1008}, 4'b0000);
    vecs[2] = mk(4'd1, 32'h2002, 8'd2, 3'd0, 2'b00, 32'hFFFF_FFFF, 3,
                 {32'h0, 32'h2000, 32'h2000, 32'h2000}, 4'b0000);
    vecs[3] = mk(4'd2, 32'h1000, 8'd2, 3'd2, 2'b10, 32'hFFFF_FFFF, 0,
                 {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0111);
    vecs[4] = mk(4'd4, 32'h3000, 8'd0, 3'd3, 2'b01, 32'hFFFF_FFFF, 0,
                 {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0001);
    vecs[5] = mk(4'd6, 32'h4000, 8'd2, 3'd2, 2'b01, 32'h4004, 3,
                 {32'h0, 32'h4008, 32'h4004, 32'h4000}, 4'b0010);
    vecs[6] = mk(4'd9, 32'h4100, 8'd1, 3'd2, 2'b11, 32'hFFFF_FFFF, 0,
                 {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0011);
    vecs[7] = mk(4'd10, 32'h5003, 8'd3, 3'd1, 2'b01, 32'hFFFF_FFFF, 4,
                 {32'h5008, 32'h5004, 32'h5004, 32'h5000}, 4'b0000);
    vecs[8] = mk(4'd11, 32'h6004, 8'd1, 3'd2, 2'b10, 32'hFFFF_FFFF, 2,
                 {32'h0, 32'h0, 32'h6000, 32'h6004}, 4'b0000);

    arst_ni = 1'b0; ar_valid_i = 1'b0; r_ready_i = 1'b1;
    ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0; ar_size_i = '0; ar_burst_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_outputs", 64'({ar_ready_o, r_valid_o, r_last_o, r_resp_o, r_data_o, r_id_o, mem_req_o}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    @(negedge clk_i) arst_ni = 1'b1;
    @(posedge clk_i);
    #1 chk("ar_ready_after_rst", 64'(ar_ready_o), 64'd1);

    for (int k = 0; k < 9; k++) begin
      push_vec(vecs[k]);
      send_ar(vecs[k]);
      wait_drain();
    end

    // Latency and backpressure on beat 1 of an INCR len 1 burst.
    v = mk(4'd7, 32'h7000, 8'd1, 3'd2, 2'b01, 32'hFFFF_FFFF, 2,
           {32'h0, 32'h0, 32'h7004, 32'h7000}, 4'b0000);
    r_ready_i = 1'b0;
    push_vec(v);
    send_ar(v);
    chk("lat_mem_req", 64'({mem_req_o, r_valid_o}), 64'b10);
    @(posedge clk_i); #1;
    chk("lat_data_cycle", 64'({mem_req_o, r_valid_o}), 64'b00);
    @(posedge clk_i); #1;
    chk("lat_r_valid", 64'({mem_req_o, r_valid_o, r_last_o}), 64'b010);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
      chk("bp_stall", 64'({mem_req_o, r_valid_o}), 64'b01);
    end
    r_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("bp_next_req", 64'({mem_req_o, r_valid_o}), 64'b10);
    wait_drain();

    // Reset while beat 2 of an INCR len 3 burst is presented.
    v = mk(4'd8, 32'h8000, 8'd3, 3'd2, 2'b01, 32'hFFFF_FFFF, 4,
           {32'h800C, 32'h8008, 32'h8004, 32'h8000}, 4'b0000);
    r_ready_i = 1'b0;
    push_vec(v);
    send_ar(v);
    wait_rvalid();
    r_ready_i = 1'b1;
    @(posedge clk_i); #1;
    r_ready_i = 1'b0;
    wait_rvalid();
    chk("pre_rst_beat2", 64'({r_valid_o, r_last_o, r_data_o}), 64'({1'b1, 1'b0, mdata(32'h8004)}));
    #2 arst_ni = 1'b0;
    #1 chk("rst_mid_burst", 64'({r_valid_o, r_last_o, mem_req_o, ar_ready_o}), 64'd0);
    exp_maddr.delete();
    exp_beat.delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) arst_ni = 1'b1;
    @(posedge clk_i);
    #1 chk("ar_ready_after_mid_rst", 64'({ar_ready_o, r_valid_o}), 64'b10);
    r_ready_i = 1'b1;
    v = mk(4'd12, 32'h9000, 8'd0, 3'd2, 2'b01, 32'hFFFF_FFFF, 1,
           {32'h0, 32'h0, 32'h0, 32'h9000}, 4'b0000);
    push_vec(v);
    send_ar(v);
    wait_drain();

    repeat (2) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
